// File: rtl/chunked_serial_adder_if.sv
// Handshake bundle for chunked_serial_adder: operand request channel and
// result response channel. The master side issues operations and consumes
// results; the slave side is the adder.
interface chunked_serial_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryin;
    logic             subtract;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;

    modport master (
        output in_valid, a, b, carryin, subtract, out_ready,
        input  in_ready, out_valid, sum, carryout, overflow
    );

    modport slave (
        input  in_valid, a, b, carryin, subtract, out_ready,
        output in_ready, out_valid, sum, carryout, overflow
    );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle two's-complement adder/subtractor. Operands are latched on
// accept, then CHUNK bits are added per clock with a 1-bit carry register
// between slices. The visible result registers only load on the final slice,
// so partial sums never reach the outputs.
module chunked_serial_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    chunked_serial_adder_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;      // already inverted in subtract mode
    logic [WIDTH-1:0] part_reg;   // slices completed so far
    logic [WIDTH-1:0] part_next;  // part_reg with the current slice merged in
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [CHUNK-1:0] a_slice [NCHUNK];
    logic [CHUNK-1:0] b_slice [NCHUNK];
    logic [CHUNK:0]   slice_sum;
    logic             last_slice;
    logic             accept;

    // Split the latched operands into slices and merge the current slice
    // result into the partial sum without a variable-width part-select.
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
            assign a_slice[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_slice[gi] = b_reg[gi*CHUNK +: CHUNK];
            assign part_next[gi*CHUNK +: CHUNK] =
                (cnt_reg == CNT_W'(gi)) ? slice_sum[CHUNK-1:0]
                                        : part_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign slice_sum  = {1'b0, a_slice[cnt_reg]} + {1'b0, b_slice[cnt_reg]}
                      + {{CHUNK{1'b0}}, carry_reg};
    assign last_slice = (cnt_reg == CNT_W'(NCHUNK - 1));
    assign accept     = (state_reg == IDLE) && bus.in_valid;

    assign bus.in_ready  = (state_reg == IDLE) && !reset;
    assign bus.out_valid = (state_reg == DONE);
    assign bus.sum       = sum_reg;
    assign bus.carryout  = cout_reg;
    assign bus.overflow  = ovf_reg;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept only in IDLE, finish on the last slice,
    // release the result on the output handshake.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid)  state_next = RUN;
            RUN:     if (last_slice)    state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, add one slice per RUN edge,
    // and load the visible result only on the final slice.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            part_reg  <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_reg     <= bus.a;
            b_reg     <= bus.subtract ? ~bus.b : bus.b;
            carry_reg <= bus.subtract ? 1'b1 : bus.carryin;
            cnt_reg   <= '0;
            part_reg  <= '0;
        end else if (state_reg == RUN) begin
            part_reg  <= part_next;
            carry_reg <= slice_sum[CHUNK];
            cnt_reg   <= cnt_reg + CNT_W'(1);
            if (last_slice) begin
                sum_reg  <= part_next;
                cout_reg <= slice_sum[CHUNK];
                ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                            (part_next[WIDTH-1] != a_reg[WIDTH-1]);
            end
        end
    end
endmodule
